// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter in front of the SDRAM controller s1 slave: locked grant across stalls,
// bounded A run length, and an in-order tag FIFO that routes read data back to its issuer.
module sdram_port_arbiter #(
    parameter int unsigned MAX_PENDING = 8,
    parameter int unsigned A_RUN_LIMIT = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset,

    input  logic [24:0] a_address,
    input  logic        a_read,
    input  logic        a_write,
    input  logic [15:0] a_writedata,
    input  logic [1:0]  a_byteenable,
    output logic        a_waitrequest,
    output logic [15:0] a_readdata,
    output logic        a_readdatavalid,

    input  logic [24:0] b_address,
    input  logic        b_read,
    input  logic        b_write,
    input  logic [15:0] b_writedata,
    input  logic [1:0]  b_byteenable,
    output logic        b_waitrequest,
    output logic [15:0] b_readdata,
    output logic        b_readdatavalid,

    output logic [24:0] m_address,
    output logic [1:0]  m_byteenable_n,
    output logic        m_chipselect,
    output logic [15:0] m_writedata,
    output logic        m_read_n,
    output logic        m_write_n,
    input  logic [15:0] m_readdata,
    input  logic        m_readdatavalid,
    input  logic        m_waitrequest
);

    localparam int unsigned PtrW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int unsigned CntW = $clog2(MAX_PENDING) + 1;

    typedef enum logic {OwnA, OwnB} owner_e;

    logic                   lock_q, lock_d;
    owner_e                 lock_owner_q;
    logic [7:0]             run_cnt_q, run_cnt_d;
    logic [MAX_PENDING-1:0] tag_q;
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]        count_q, count_d;
    logic                   pop_err_q;
    logic                   a_rdv_q, b_rdv_q;
    logic [15:0]            a_rdata_q, b_rdata_q;

    logic        read_ok, a_pres, b_pres, b_valid;
    logic        has_owner;
    owner_e      owner;
    logic        own_read, own_write, cmd_valid;
    logic [24:0] own_addr;
    logic [15:0] own_wdata;
    logic [1:0]  own_be;
    logic        accept, acc_a, acc_b, push, pop, pop_ok;
    owner_e      pop_tag;

    // Eligibility uses the count before this cycle's pop.
    assign read_ok = count_q < CntW'(MAX_PENDING);
    assign a_pres  = a_read ? read_ok : a_write;
    assign b_pres  = b_read ? read_ok : b_write;
    assign b_valid = b_read | b_write;

    always_comb begin
        has_owner = 1'b0;
        owner     = OwnA;
        if (lock_q) begin
            has_owner = 1'b1;
            owner     = lock_owner_q;
        end else if (a_pres && b_pres) begin
            has_owner = 1'b1;
            owner     = (run_cnt_q >= 8'(A_RUN_LIMIT)) ? OwnB : OwnA;
        end else if (a_pres) begin
            has_owner = 1'b1;
        end else if (b_pres) begin
            has_owner = 1'b1;
            owner     = OwnB;
        end
    end

    always_comb begin
        if (owner == OwnB) begin
            own_read  = b_read;
            own_write = b_write;
            own_addr  = b_address;
            own_wdata = b_writedata;
            own_be    = b_byteenable;
        end else begin
            own_read  = a_read;
            own_write = a_write;
            own_addr  = a_address;
            own_wdata = a_writedata;
            own_be    = a_byteenable;
        end
    end

    assign cmd_valid      = has_owner & (own_read | own_write);
    assign m_chipselect   = cmd_valid;
    assign m_read_n       = ~(cmd_valid & own_read);
    assign m_write_n      = ~(cmd_valid & own_write & ~own_read);
    assign m_address      = cmd_valid ? own_addr : '0;
    assign m_writedata    = cmd_valid ? own_wdata : '0;
    assign m_byteenable_n = cmd_valid ? ~own_be : 2'b11;

    assign a_waitrequest = (has_owner && owner == OwnA) ? m_waitrequest : 1'b1;
    assign b_waitrequest = (has_owner && owner == OwnB) ? m_waitrequest : 1'b1;

    assign accept  = cmd_valid & ~m_waitrequest;
    assign acc_a   = accept & (owner == OwnA);
    assign acc_b   = accept & (owner == OwnB);
    assign push    = accept & own_read;
    assign pop     = m_readdatavalid;
    assign pop_ok  = pop & (count_q != '0);
    assign pop_tag = owner_e'(tag_q[rd_ptr_q]);

    always_comb begin
        lock_d = cmd_valid & m_waitrequest;

        run_cnt_d = run_cnt_q;
        if (acc_b || !b_valid) begin
            run_cnt_d = 8'd0;
        end else if (acc_a && run_cnt_q != 8'hFF) begin
            run_cnt_d = run_cnt_q + 8'd1;
        end

        count_d = count_q;
        if (push && !pop_ok) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop_ok) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OwnA;
            run_cnt_q    <= 8'd0;
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pop_err_q    <= 1'b0;
            a_rdv_q      <= 1'b0;
            b_rdv_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= owner;
            run_cnt_q    <= run_cnt_d;
            count_q      <= count_d;
            if (push) begin
                tag_q[wr_ptr_q] <= (owner == OwnB);
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            // Data with no outstanding read is dropped and flagged, never strobed.
            if (pop && !pop_ok) begin
                pop_err_q <= 1'b1;
            end
            a_rdv_q <= pop_ok & (pop_tag == OwnA);
            b_rdv_q <= pop_ok & (pop_tag == OwnB);
            if (pop_ok && pop_tag == OwnA) begin
                a_rdata_q <= m_readdata;
            end
            if (pop_ok && pop_tag == OwnB) begin
                b_rdata_q <= m_readdata;
            end
        end
    end

    assign a_readdatavalid = a_rdv_q;
    assign b_readdatavalid = b_rdv_q;
    assign a_readdata      = a_rdata_q;
    assign b_readdata      = b_rdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter; returned read data is checked against per-requester
// expectation queues filled when the controller model drives readdatavalid.
module tb_sdram_port_arbiter;

    logic        clk_clk, reset_reset;
    logic [24:0] a_address, b_address, m_address;
    logic        a_read, a_write, b_read, b_write;
    logic [15:0] a_writedata, b_writedata, a_readdata, b_readdata, m_writedata, m_readdata;
    logic [1:0]  a_byteenable, b_byteenable, m_byteenable_n;
    logic        a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid;
    logic        m_chipselect, m_read_n, m_write_n, m_readdatavalid, m_waitrequest;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    logic [15:0] mon_a, mon_b;

    localparam logic [24:0] AddrA = 25'h000AAAA;
    localparam logic [24:0] AddrB = 25'h000BBBB;

    sdram_port_arbiter #(.MAX_PENDING(8), .A_RUN_LIMIT(4)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .a_address(a_address), .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
        .a_byteenable(a_byteenable), .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
        .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
        .b_byteenable(b_byteenable), .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
        .b_readdatavalid(b_readdatavalid),
        .m_address(m_address), .m_byteenable_n(m_byteenable_n), .m_chipselect(m_chipselect),
        .m_writedata(m_writedata), .m_read_n(m_read_n), .m_write_n(m_write_n),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .m_waitrequest(m_waitrequest)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic ret(input logic [15:0] d, input logic to_b);
        m_readdatavalid = 1'b1;
        m_readdata      = d;
        if (to_b) exp_b.push_back(d);
        else      exp_a.push_back(d);
        cyc();
        m_readdatavalid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cs"}, 32'(m_chipselect), 32'(0));
        chk({tag, "_read_n"}, 32'(m_read_n), 32'(1));
        chk({tag, "_write_n"}, 32'(m_write_n), 32'(1));
        chk({tag, "_be_n"}, 32'(m_byteenable_n), 32'(3));
        chk({tag, "_addr"}, 32'(m_address), 32'(0));
        chk({tag, "_wdata"}, 32'(m_writedata), 32'(0));
        chk({tag, "_a_wait"}, 32'(a_waitrequest), 32'(1));
        chk({tag, "_b_wait"}, 32'(b_waitrequest), 32'(1));
        chk({tag, "_a_rdv"}, 32'(a_readdatavalid), 32'(0));
        chk({tag, "_b_rdv"}, 32'(b_readdatavalid), 32'(0));
        chk({tag, "_a_rdata"}, 32'(a_readdata), 32'(0));
        chk({tag, "_b_rdata"}, 32'(b_readdata), 32'(0));
    endtask

    // Read-return scoreboard, sampled on the falling edge.
    always @(negedge clk_clk) begin
        if (a_readdatavalid === 1'b1) begin
            if (exp_a.size() > 0) begin
                mon_a = exp_a.pop_front();
                chk("a_rdata", 32'(a_readdata), 32'(mon_a));
            end else begin
                chk("a_unexpected_strobe", 32'(a_readdatavalid), 32'(0));
            end
        end
        if (b_readdatavalid === 1'b1) begin
            if (exp_b.size() > 0) begin
                mon_b = exp_b.pop_front();
                chk("b_rdata", 32'(b_readdata), 32'(mon_b));
            end else begin
                chk("b_unexpected_strobe", 32'(b_readdatavalid), 32'(0));
            end
        end
    end

    initial begin
        logic [4:0] pat;
        a_address = '0; a_read = 0; a_write = 0; a_writedata = '0; a_byteenable = 2'b11;
        b_address = '0; b_read = 0; b_write = 0; b_writedata = '0; b_byteenable = 2'b11;
        m_readdata = '0; m_readdatavalid = 0; m_waitrequest = 0;
        reset_reset = 1'b1;
        repeat (2) cyc();
        check_idle_outputs("reset");
        reset_reset = 1'b0;
        cyc();

        // Single A read, data returned a few cycles later.
        a_read = 1; a_address = 25'h0000100;
        #1;
        chk("t1_cs", 32'(m_chipselect), 32'(1));
        chk("t1_read_n", 32'(m_read_n), 32'(0));
        chk("t1_addr", 32'(m_address), 32'h100);
        chk("t1_a_wait", 32'(a_waitrequest), 32'(0));
        chk("t1_b_wait", 32'(b_waitrequest), 32'(1));
        cyc();
        a_read = 0;
        repeat (2) cyc();
        ret(16'hBEEF, 1'b0);
        chk("t1_a_rdv", 32'(a_readdatavalid), 32'(1));
        chk("t1_a_rdata", 32'(a_readdata), 32'hBEEF);
        chk("t1_b_rdv", 32'(b_readdatavalid), 32'(0));
        cyc();

        // Both reading continuously: AAAAB repeating, each read returned the next cycle.
        a_read = 1; a_address = AddrA;
        b_read = 1; b_address = AddrB;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                m_readdatavalid = 1'b1;
                m_readdata      = 16'h2000 + 16'(k - 1);
                if (((k - 1) % 5) == 4) exp_b.push_back(m_readdata);
                else                    exp_a.push_back(m_readdata);
            end
            #1;
            chk($sformatf("t2_addr_%0d", k), 32'(m_address),
                32'((k % 5 == 4) ? AddrB : AddrA));
            chk($sformatf("t2_a_wait_%0d", k), 32'(a_waitrequest), 32'(k % 5 == 4));
            cyc();
        end
        a_read = 0; b_read = 0;
        ret(16'h2009, 1'b1);
        cyc();

        // B write stalled 5 cycles; A's later read must not steal the grant.
        m_waitrequest = 1;
        b_write = 1; b_address = 25'h1ABCDEF; b_writedata = 16'hCAFE; b_byteenable = 2'b01;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a_read = 1; a_address = 25'h0000200;
            end
            #1;
            chk($sformatf("t3_addr_%0d", i), 32'(m_address), 32'h1ABCDEF);
            chk($sformatf("t3_wdata_%0d", i), 32'(m_writedata), 32'hCAFE);
            chk($sformatf("t3_be_n_%0d", i), 32'(m_byteenable_n), 32'(2'b10));
            chk($sformatf("t3_write_n_%0d", i), 32'(m_write_n), 32'(0));
            chk($sformatf("t3_a_wait_%0d", i), 32'(a_waitrequest), 32'(1));
            cyc();
        end
        m_waitrequest = 0;
        #1;
        chk("t3_b_accept", 32'(b_waitrequest), 32'(0));
        chk("t3_addr_acc", 32'(m_address), 32'h1ABCDEF);
        cyc();
        b_write = 0;
        #1;
        chk("t3_a_next_addr", 32'(m_address), 32'h200);
        chk("t3_a_next_wait", 32'(a_waitrequest), 32'(0));
        cyc();
        a_read = 0;
        ret(16'h3333, 1'b0);
        cyc();

        // Read backlog: 8 accepted, 9th held, writes still pass, one return frees a slot.
        a_read = 1; a_address = 25'h0000300;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t4_a_wait_%0d", i), 32'(a_waitrequest), 32'(0));
            cyc();
        end
        #1;
        chk("t4_full_a_wait", 32'(a_waitrequest), 32'(1));
        chk("t4_full_cs", 32'(m_chipselect), 32'(0));
        b_write = 1; b_address = 25'h0000400; b_writedata = 16'h1111; b_byteenable = 2'b11;
        #1;
        chk("t4_bw_cs", 32'(m_chipselect), 32'(1));
        chk("t4_bw_write_n", 32'(m_write_n), 32'(0));
        chk("t4_bw_addr", 32'(m_address), 32'h400);
        chk("t4_bw_wait", 32'(b_waitrequest), 32'(0));
        cyc();
        b_write = 0;
        m_readdatavalid = 1; m_readdata = 16'h4000; exp_a.push_back(16'h4000);
        #1;
        chk("t4_pop_cycle_a_wait", 32'(a_waitrequest), 32'(1));
        cyc();
        m_readdatavalid = 0;
        #1;
        chk("t4_after_pop_a_wait", 32'(a_waitrequest), 32'(0));
        chk("t4_after_pop_addr", 32'(m_address), 32'h300);
        cyc();
        a_read = 0;
        for (int i = 1; i <= 8; i++) ret(16'h4000 + 16'(i), 1'b0);
        cyc();

        // Interleaved A,B,A,A,B accepts; returns must route in order.
        pat = 5'b10010;
        a_address = 25'h0000600; b_address = 25'h0000700;
        for (int i = 0; i < 5; i++) begin
            a_read = ~pat[i]; b_read = pat[i];
            #1;
            chk($sformatf("t5_own_wait_%0d", i),
                32'(pat[i] ? b_waitrequest : a_waitrequest), 32'(0));
            cyc();
        end
        a_read = 0; b_read = 0;
        for (int i = 0; i < 5; i++) ret(16'(i + 1), pat[i]);
        repeat (2) cyc();

        // Reset with 3 reads outstanding; later returns are dropped and flagged.
        a_read = 1; a_address = 25'h0000500;
        repeat (3) cyc();
        a_read = 0;
        chk("t6_err_before", 32'(dut.pop_err_q), 32'(0));
        reset_reset = 1;
        cyc();
        check_idle_outputs("t6_reset");
        reset_reset = 0;
        cyc();
        m_readdatavalid = 1; m_readdata = 16'hDEAD;
        repeat (3) cyc();
        m_readdatavalid = 0;
        repeat (3) cyc();
        chk("t6_err_after", 32'(dut.pop_err_q), 32'(1));
        chk("t6_a_rdata_held", 32'(a_readdata), 32'(0));

        chk("a_queue_drained", 32'(exp_a.size()), 32'(0));
        chk("b_queue_drained", 32'(exp_b.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
